// File: rtl/wb_writeback.sv
// RV32I writeback stage: 2-entry result FIFO feeding the register file write port,
// with load extraction at push time and forwarding lookup. Optional macro: LOAD_MISALIGN_TRAP_EN.
module wb_writeback #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          MEM_valid,
  output logic                          MEM_ready,
  input  logic [REGFILE_ADDR_WIDTH-1:0] MEM_rd_addr,
  input  logic                          MEM_rd_wr_en,
  input  logic [1:0]                    MEM_wb_sel,
  input  logic [2:0]                    MEM_funct3,
  input  logic [REG_DATA_WIDTH-1:0]     MEM_alu_result,
  input  logic [REG_DATA_WIDTH-1:0]     MEM_load_data,
  input  logic [REG_DATA_WIDTH-1:0]     MEM_pc_plus4,
  input  logic                          Rf_wr_ready,
  output logic [REGFILE_ADDR_WIDTH-1:0] Rd_addr,
  output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
  output logic                          Rd_wr_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Fwd_rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] Fwd_rs2_addr,
  output logic                          Fwd_rs1_hit,
  output logic                          Fwd_rs2_hit,
  output logic [REG_DATA_WIDTH-1:0]     Fwd_rs1_data,
  output logic [REG_DATA_WIDTH-1:0]     Fwd_rs2_data,
  output logic                          Misaligned_err,
  output logic [31:0]                   Retired_count
);

  typedef struct packed {
    logic [REGFILE_ADDR_WIDTH-1:0] rd;
    logic                          wr_en;
    logic [REG_DATA_WIDTH-1:0]     data;
`ifdef LOAD_MISALIGN_TRAP_EN
    logic                          mis;
`endif
  } entry_t;

  entry_t      slot_q [2];
  entry_t      slot_d [2];
  entry_t      push_ent;
  logic [1:0]  count_q, count_d;
  logic [31:0] ret_q, ret_d;
  logic        push, pop, head_v;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [REG_DATA_WIDTH-1:0] ld_val;

  // Entry may write rd and be seen by forwarding.
  function automatic logic live(entry_t e);
`ifdef LOAD_MISALIGN_TRAP_EN
    return e.wr_en && (e.rd != '0) && !e.mis;
`else
    return e.wr_en && (e.rd != '0);
`endif
  endfunction

  assign off       = MEM_alu_result[1:0];
  assign head_v    = (count_q != 2'd0);
  assign MEM_ready = (count_q < 2'd2);
  assign push      = MEM_valid && MEM_ready;
  assign pop       = head_v && Rf_wr_ready;

  always_comb begin
    ld_byte = MEM_load_data[7:0];
    case (off)
      2'd1: ld_byte = MEM_load_data[15:8];
      2'd2: ld_byte = MEM_load_data[23:16];
      2'd3: ld_byte = MEM_load_data[31:24];
      default: ;
    endcase
    ld_half = off[1] ? MEM_load_data[31:16] : MEM_load_data[15:0];
    case (MEM_funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = MEM_load_data;
    endcase
  end

  always_comb begin
    push_ent       = '0;
    push_ent.rd    = MEM_rd_addr;
    push_ent.wr_en = MEM_rd_wr_en;
    case (MEM_wb_sel)
      2'b01:   push_ent.data = ld_val;
      2'b10:   push_ent.data = MEM_pc_plus4;
      default: push_ent.data = MEM_alu_result;
    endcase
`ifdef LOAD_MISALIGN_TRAP_EN
    // Byte loads never misalign; anything not byte/half is word-class.
    push_ent.mis = (MEM_wb_sel == 2'b01) &&
      (((MEM_funct3[1:0] == 2'b01) && off[0]) ||
       ((MEM_funct3[1:0] != 2'b00) && (MEM_funct3[1:0] != 2'b01) && (off != 2'd0)) ||
       ((MEM_funct3 == 3'b011 || MEM_funct3 == 3'b111) && (off != 2'd0)));
`endif
  end

  // Slot 0 is always the head; pop shifts slot 1 down.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    ret_d   = pop ? ret_q + 32'd1 : ret_q;
    if (pop) slot_d[0] = slot_q[1];
    if (push) begin
      if (count_q == 2'd1 && !pop) slot_d[1] = push_ent;
      else                         slot_d[0] = push_ent;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
      ret_q     <= 32'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      count_q   <= count_d;
      ret_q     <= ret_d;
    end
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge Clk) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= pop && slot_q[0].mis;
  end
  assign Misaligned_err = err_q;
`else
  assign Misaligned_err = 1'b0;
`endif

  assign Retired_count = ret_q;
  assign Rd_addr       = head_v ? slot_q[0].rd : '0;
  assign Rd_wr_data    = head_v ? slot_q[0].data : '0;
  assign Rd_wr_en      = pop && live(slot_q[0]);

  // Younger (slot 1) match is checked first so it wins over the head.
  always_comb begin
    Fwd_rs1_hit  = 1'b0;
    Fwd_rs1_data = '0;
    Fwd_rs2_hit  = 1'b0;
    Fwd_rs2_data = '0;
    if (count_q == 2'd2 && live(slot_q[1]) && slot_q[1].rd == Fwd_rs1_addr) begin
      Fwd_rs1_hit = 1'b1; Fwd_rs1_data = slot_q[1].data;
    end else if (head_v && live(slot_q[0]) && slot_q[0].rd == Fwd_rs1_addr) begin
      Fwd_rs1_hit = 1'b1; Fwd_rs1_data = slot_q[0].data;
    end
    if (count_q == 2'd2 && live(slot_q[1]) && slot_q[1].rd == Fwd_rs2_addr) begin
      Fwd_rs2_hit = 1'b1; Fwd_rs2_data = slot_q[1].data;
    end else if (head_v && live(slot_q[0]) && slot_q[0].rd == Fwd_rs2_addr) begin
      Fwd_rs2_hit = 1'b1; Fwd_rs2_data = slot_q[0].data;
    end
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Randomized + directed bench for wb_writeback against a queue-based reference model.
module tb_wb_writeback;
  logic        Clk = 1'b0;
  logic        Reset_n, MEM_valid, MEM_ready, MEM_rd_wr_en, Rf_wr_ready, Rd_wr_en;
  logic [4:0]  MEM_rd_addr, Rd_addr, Fwd_rs1_addr, Fwd_rs2_addr;
  logic [1:0]  MEM_wb_sel;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_alu_result, MEM_load_data, MEM_pc_plus4, Rd_wr_data;
  logic        Fwd_rs1_hit, Fwd_rs2_hit, Misaligned_err;
  logic [31:0] Fwd_rs1_data, Fwd_rs2_data, Retired_count;

  wb_writeback dut (
    .Clk(Clk), .Reset_n(Reset_n), .MEM_valid(MEM_valid), .MEM_ready(MEM_ready),
    .MEM_rd_addr(MEM_rd_addr), .MEM_rd_wr_en(MEM_rd_wr_en), .MEM_wb_sel(MEM_wb_sel),
    .MEM_funct3(MEM_funct3), .MEM_alu_result(MEM_alu_result), .MEM_load_data(MEM_load_data),
    .MEM_pc_plus4(MEM_pc_plus4), .Rf_wr_ready(Rf_wr_ready), .Rd_addr(Rd_addr),
    .Rd_wr_data(Rd_wr_data), .Rd_wr_en(Rd_wr_en), .Fwd_rs1_addr(Fwd_rs1_addr),
    .Fwd_rs2_addr(Fwd_rs2_addr), .Fwd_rs1_hit(Fwd_rs1_hit), .Fwd_rs2_hit(Fwd_rs2_hit),
    .Fwd_rs1_data(Fwd_rs1_data), .Fwd_rs2_data(Fwd_rs2_data),
    .Misaligned_err(Misaligned_err), .Retired_count(Retired_count)
  );

  always #5 Clk = ~Clk;

`ifdef LOAD_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct { logic [4:0] rd; bit wen; logic [31:0] data; bit mis; } m_t;
  m_t          q[$];
  int          vec = 0, miscompares = 0;
  bit          known = 0;
  bit          exp_err = 0;
  logic [31:0] exp_ret = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [1:0] sel, input logic [2:0] f3,
      input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
    int unsigned off = alu % 4;
    logic [31:0] b, h;
    if (sel == 2) return pc;
    if (sel != 1) return alu;
    b = (ld >> (8 * off)) & 32'hFF;
    h = (ld >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return ld;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu);
    int unsigned off = alu % 4;
    if (!TRAP || sel != 1) return 0;
    if (f3 == 0 || f3 == 4) return 0;
    if (f3 == 1 || f3 == 5) return (off % 2) == 1;
    return off != 0;
  endfunction

  function automatic bit ref_live(input m_t e);
    return e.wen && e.rd != 0 && !e.mis;
  endfunction

  task automatic step(input bit rst, input bit v, input logic [4:0] rd, input bit wen,
      input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
      input logic [31:0] pc, input bit rfr, input logic [4:0] rs1, input logic [4:0] rs2);
    bit push, pop, h1, h2;
    logic [31:0] d1, d2;
    m_t e;
    Reset_n = ~rst; MEM_valid = v; MEM_rd_addr = rd; MEM_rd_wr_en = wen; MEM_wb_sel = sel;
    MEM_funct3 = f3; MEM_alu_result = alu; MEM_load_data = ld; MEM_pc_plus4 = pc;
    Rf_wr_ready = rfr; Fwd_rs1_addr = rs1; Fwd_rs2_addr = rs2;
    #1;
    if (known) begin
      h1 = 0; d1 = 0; h2 = 0; d2 = 0;
      foreach (q[i]) begin
        if (ref_live(q[i]) && q[i].rd == rs1) begin h1 = 1; d1 = q[i].data; end
        if (ref_live(q[i]) && q[i].rd == rs2) begin h2 = 1; d2 = q[i].data; end
      end
      chk("mem_ready", MEM_ready, q.size() < 2);
      chk("rd_addr", Rd_addr, q.size() > 0 ? q[0].rd : 0);
      chk("rd_data", Rd_wr_data, q.size() > 0 ? q[0].data : 0);
      chk("rd_wr_en", Rd_wr_en, q.size() > 0 && rfr && ref_live(q[0]));
      chk("fwd1_hit", Fwd_rs1_hit, h1);
      chk("fwd1_data", Fwd_rs1_data, d1);
      chk("fwd2_hit", Fwd_rs2_hit, h2);
      chk("fwd2_data", Fwd_rs2_data, d2);
      chk("mis_err", Misaligned_err, exp_err);
      chk("retired", Retired_count, exp_ret);
    end
    pop  = q.size() > 0 && rfr;
    push = v && q.size() < 2;
    e.rd = rd; e.wen = wen; e.data = ref_val(sel, f3, alu, ld, pc); e.mis = ref_mis(sel, f3, alu);
    @(posedge Clk);
    if (rst) begin
      q.delete(); exp_ret = 0; exp_err = 0; known = 1;
    end else begin
      exp_err = pop && q[0].mis;
      if (pop) begin void'(q.pop_front()); exp_ret++; end
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input bit rfr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rfr, 7, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, 0, 0, 32'h55, 0, 0, 1, 3, 0);
    // back-to-back ALU ops
    step(0, 1, 5, 1, 0, 0, 32'h11, 0, 0, 1, 5, 6);
    step(0, 1, 6, 1, 0, 0, 32'h22, 0, 0, 1, 5, 6);
    idle(1); idle(1);
    // LB / LBU at offset 3, LHU at offset 2
    step(0, 1, 8, 1, 1, 3'b000, 32'h3, 32'h80FF_0000, 0, 1, 8, 0);
    step(0, 1, 9, 1, 1, 3'b100, 32'h3, 32'h80FF_0000, 0, 1, 9, 0);
    step(0, 1, 10, 1, 1, 3'b101, 32'h2, 32'h80FF_0000, 0, 1, 10, 0);
    step(0, 1, 11, 1, 2, 0, 0, 0, 32'h1234, 1, 11, 0);
    idle(1);
    // stalled port: 3 offered, 2 accepted, younger rd=7 wins forwarding
    step(0, 1, 7, 1, 0, 0, 32'hA, 0, 0, 0, 7, 0);
    step(0, 1, 7, 1, 0, 0, 32'hB, 0, 0, 0, 7, 0);
    step(0, 1, 4, 1, 0, 0, 32'hC, 0, 0, 0, 7, 0);
    step(0, 1, 4, 1, 0, 0, 32'hC, 0, 0, 1, 7, 0);
    idle(1); idle(1);
    // rd=0 entry never writes or forwards
    step(0, 1, 0, 1, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    idle(1); idle(1);
    // misaligned LW and LH
    step(0, 1, 12, 1, 1, 3'b010, 32'h2, 32'hCAFE_BABE, 0, 1, 12, 0);
    step(0, 1, 13, 1, 1, 3'b001, 32'h1, 32'hCAFE_BABE, 0, 1, 13, 0);
    idle(1); idle(1);
    // reset with two entries buffered
    step(0, 1, 14, 1, 0, 0, 32'h1, 0, 0, 0, 14, 0);
    step(0, 1, 15, 1, 0, 0, 32'h2, 0, 0, 0, 15, 0);
    step(1, 1, 16, 1, 0, 0, 32'h3, 0, 0, 1, 14, 15);
    idle(1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0, 5'($urandom_range(0, 7)), ($urandom % 5) != 0,
           2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, ($urandom % 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end
endmodule
